// File: rtl/idu32_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : idu32_decode_stage (with IDU32_Decoder)
// Description : Instruction-decode stage between fetch and execute. Classifies
//               the opcode, selects the matching immediate, registers the
//               result behind a one-entry skid buffer, and counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================

module IDU32_Decoder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
endmodule

module idu32_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [2:0] c_TYPE_R       = 3'd0;
    localparam logic [2:0] c_TYPE_I       = 3'd1;
    localparam logic [2:0] c_TYPE_S       = 3'd2;
    localparam logic [2:0] c_TYPE_B       = 3'd3;
    localparam logic [2:0] c_TYPE_U       = 3'd4;
    localparam logic [2:0] c_TYPE_J       = 3'd5;
    localparam logic [2:0] c_TYPE_ILLEGAL = 3'd7;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0]  w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    entry_t           w_in_entry;
    entry_t           r_main, r_skid;
    logic             r_main_valid, r_skid_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_fire, w_out_fire;

    IDU32_Decoder #(.XLEN(XLEN)) u_imm_dec (
        .inst  (in_inst),
        .imm_i (w_imm_i),
        .imm_s (w_imm_s),
        .imm_b (w_imm_b),
        .imm_u (w_imm_u),
        .imm_j (w_imm_j)
    );

    always_comb begin
        w_in_entry          = '0;
        w_in_entry.inst     = in_inst;
        w_in_entry.pc       = in_pc;
        w_in_entry.imm_type = c_TYPE_ILLEGAL;
        w_in_entry.illegal  = 1'b1;
        if (in_inst[1:0] == 2'b11) begin
            w_in_entry.illegal = 1'b0;
            case (in_inst[6:0])
                7'b0110111, 7'b0010111: begin
                    w_in_entry.imm_type = c_TYPE_U;
                    w_in_entry.imm      = w_imm_u;
                end
                7'b1101111: begin
                    w_in_entry.imm_type = c_TYPE_J;
                    w_in_entry.imm      = w_imm_j;
                end
                7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: begin
                    w_in_entry.imm_type = c_TYPE_I;
                    w_in_entry.imm      = w_imm_i;
                end
                7'b0100011: begin
                    w_in_entry.imm_type = c_TYPE_S;
                    w_in_entry.imm      = w_imm_s;
                end
                7'b1100011: begin
                    w_in_entry.imm_type = c_TYPE_B;
                    w_in_entry.imm      = w_imm_b;
                end
                7'b0110011: begin
                    w_in_entry.imm_type = c_TYPE_R;
                end
                default: begin
                    w_in_entry.imm_type = c_TYPE_ILLEGAL;
                    w_in_entry.illegal  = 1'b1;
                end
            endcase
        end
    end

    // in_ready depends only on skid occupancy, keeping out_ready off the input path
    assign in_ready   = !r_skid_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || (w_out_fire && !r_skid_valid)) begin
            r_main_valid <= w_in_fire;
            if (w_in_fire) begin
                r_main <= w_in_entry;
            end
        end else if (w_out_fire) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= w_in_fire;
            if (w_in_fire) begin
                r_skid <= w_in_entry;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_in_entry;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid    = r_main_valid;
    assign out_inst     = r_main.inst;
    assign out_pc       = r_main.pc;
    assign out_imm      = r_main.imm;
    assign out_imm_type = r_main.imm_type;
    assign out_illegal  = r_main.illegal;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/idu32_decode_stage.md
Name: idu32_decode_stage

Overview:
- Instruction-decode pipeline stage between the fetch unit and the execute unit of the 32-bit core.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode into an immediate format.
- Uses the existing combinational immediate decoder (IDU32_Decoder) to extract all five immediates, selects the one matching the classified format, and registers the result.
- Includes a one-entry skid buffer so that in_ready has no combinational path from out_ready, a pipeline flush, and a saturating back-pressure counter.

Parameters:
- XLEN, 32, width of the instruction, PC and immediate datapaths. Only 32 is supported.
- CNT_W, 16, width of the stall_cnt performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held instructions. Has priority over every other event in the same cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  32  PC of in_inst.
- out_valid  out  1  a decoded instruction is presented.
- out_ready  in  1  execute unit accepts the presented instruction.
- out_inst  out  32  registered instruction word.
- out_pc  out  32  registered PC.
- out_imm  out  32  selected sign-extended immediate.
- out_imm_type  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- out_illegal  out  1  the opcode is unrecognised or inst[1:0]!=2'b11.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (asynchronous on rst high):
  - main_valid=0, skid_valid=0.
  - All out_* data outputs = 0; out_imm_type = 0; out_illegal = 0; stall_cnt = 0.
  - in_ready = 1 once rst deasserts.
- Decode is combinational on in_inst; the result is captured together with inst and pc.
- Opcode to format (inst[6:0]):
  - 0110111 (LUI) and 0010111 (AUIPC) -> U.
  - 1101111 (JAL) -> J.
  - 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 1110011 (SYSTEM), 0001111 (MISC-MEM) -> I.
  - 0100011 (STORE) -> S.
  - 1100011 (BRANCH) -> B.
  - 0110011 (OP) -> R, with imm = 0.
  - Anything else -> ILLEGAL, imm = 0, out_illegal = 1. Illegal instructions still flow through the stage; they are not dropped.
- Storage: a main register and a skid register, each holding {inst, pc, imm, type, illegal}.
  - out_* reflect the main register; out_valid = main_valid.
  - in_ready = !skid_valid, registered (no combinational path from out_ready).
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1, when the main register is free or draining.
- Transfer rules per rising edge (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready):
  - Main empty, or out_fire with skid empty: main <= input if in_fire, else main_valid <= 0.
  - out_fire with skid full: main <= skid; skid <= input if in_fire, else skid_valid <= 0. In this case in_ready was 0, so in_fire is 0.
  - Main full, no out_fire, in_fire: skid <= input; in_ready drops to 0 in the next cycle.
  - Main full, no out_fire, no in_fire: hold all state.
- Ordering: instructions leave in acceptance order. No duplication and no loss, except on flush.
- Output stability: out_* are stable while out_valid=1 and out_ready=0.
- flush=1:
  - main_valid and skid_valid are cleared at the next edge; any in_fire in that cycle is discarded.
  - out_valid=0 and in_ready=1 in the following cycle.
  - Data registers may keep stale values.
  - stall_cnt is not cleared.
- stall_cnt:
  - Increments by 1 each cycle out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Cleared only by rst.
- rst asserted mid-operation: everything returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/idle: hold rst for 3 cycles, then release with in_valid=0 -> out_valid=0, in_ready=1, stall_cnt=0, all outputs 0.
- Immediate formats: stream, with out_ready=1, the instructions 0x00500093 (ADDI x1,x0,5), 0xFE112E23 (SW), 0xFE0008E3 (BEQ), 0x123452B7 (LUI), 0x0080006F (JAL) ->
  - ADDI: type 1, imm 0x00000005.
  - SW: type 2, imm 0xFFFFFFFC.
  - BEQ: type 3, imm 0xFFFFFFF0.
  - LUI: type 4, imm 0x12345000.
  - JAL: type 5, imm 0x00000008.
  - Each appears one cycle after acceptance, back-to-back with no bubbles.
- Illegal/R-type:
  - 0x00000000 -> type 7, out_illegal=1, imm 0.
  - 0x002081B3 (ADD) -> type 0, out_illegal=0, imm 0.
- Back-pressure/skid: feed A, B, C continuously while out_ready=0 for 4 cycles, then out_ready=1 ->
  - A and B are accepted; in_ready goes low after B.
  - A stays stable on out_*; stall_cnt=4.
  - Outputs then emerge in order A, B, C.
- Flush with both entries full: assert flush together with in_valid=1 -> the next cycle shows out_valid=0 and in_ready=1; the flushed input never appears on out_*.
- Saturation and async reset:
  - With CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt sticks at 15.
  - Assert rst between clock edges -> all outputs return to 0 before the next clock edge.
